// File: rtl/onchip_ram_pkg.sv
// Shared constants for the Avalon on-chip RAM: controller states, legal read latencies
// and the per-byte parity helper used when ONCHIP_RAM_PARITY_EN is defined.
package onchip_ram_pkg;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    // Even parity: the stored bit makes the 9-bit lane XOR to zero.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/onchip_ram_array.sv
// Single-port synchronous RAM with per-lane write enables and a registered read port.
// Reads return the pre-write contents when a read and a write hit the same address.
module onchip_ram_array #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic                    clk,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [LANES-1:0]        be_i,
    input  logic [AW-1:0]           addr_i,
    input  logic [LANES*LANE_W-1:0] wdata_i,
    output logic [LANES*LANE_W-1:0] rdata_o
);

    // One array per lane so each byte lane maps onto its own write enable.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [LANE_W-1:0] mem_q [DEPTH];
        logic [LANE_W-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (en_i) begin
                if (we_i && be_i[gi]) begin
                    mem_q[addr_i] <= wdata_i[gi*LANE_W +: LANE_W];
                end
                rd_q <= mem_q[addr_i];
            end
        end

        assign rdata_o[gi*LANE_W +: LANE_W] = rd_q;
    end

endmodule

// File: rtl/onchip_ram_avl.sv
// Avalon-MM slave around onchip_ram_array: zero-fill FSM, 1- or 2-cycle read pipeline,
// out-of-range handling. Define ONCHIP_RAM_PARITY_EN to add per-byte parity checking.
module onchip_ram_avl
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 10,
    parameter int DEPTH          = 1024,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  reset_req,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  parity_err
);

    localparam int NB = DATA_W / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef ONCHIP_RAM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [AW-1:0]   CLR_LAST  = AW'(DEPTH - 1);

    logic              en;
    logic [0:0]        state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              clearing;
    logic              accept, wr_acc, rd_acc, in_range;
    logic              ram_we;
    logic [NB-1:0]     ram_be;
    logic [AW-1:0]     ram_addr;
    logic [NB*LANE_W-1:0] ram_wdata, ram_rdata;
    logic              v1_q, oor1_q;
    logic [DATA_W-1:0] s1_data;
    logic              s1_err;
    logic              out_v, out_e;
    logic [DATA_W-1:0] out_d;

    assign en          = clken & ~reset_req;
    assign clearing    = (state_q == CLEAR);
    assign waitrequest = reset | ~en | (state_q != READY);
    assign accept      = chipselect & (read | write) & ~waitrequest;
    assign wr_acc      = accept & write;
    assign rd_acc      = accept & read & ~write;
    assign in_range    = ({1'b0, address} < DEPTH_L);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            if (clr_cnt_q == CLR_LAST) begin
                state_d = READY;
            end else begin
                clr_cnt_d = clr_cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt_q <= '0;
            v1_q      <= 1'b0;
            oor1_q    <= 1'b0;
        end else if (en) begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            v1_q      <= rd_acc;
            oor1_q    <= ~in_range;
        end
    end

    // Reset gates the write port so memory survives reset when no clear is configured.
    assign ram_we   = ~reset & (clearing | (wr_acc & in_range));
    assign ram_be   = clearing ? {NB{1'b1}} : byteenable;
    assign ram_addr = clearing ? clr_cnt_q : address[AW-1:0];

`ifdef ONCHIP_RAM_PARITY_EN
    logic [NB-1:0] lane_err;
`endif

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] wbyte;
        assign wbyte = clearing ? 8'h00 : writedata[gi*8 +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
        assign ram_wdata[gi*LANE_W +: LANE_W] = {byte_parity(wbyte), wbyte};
        assign lane_err[gi] = ^ram_rdata[gi*LANE_W +: LANE_W];
`else
        assign ram_wdata[gi*LANE_W +: LANE_W] = wbyte;
`endif
        assign s1_data[gi*8 +: 8] = oor1_q ? 8'h00 : ram_rdata[gi*LANE_W +: 8];
    end

`ifdef ONCHIP_RAM_PARITY_EN
    assign s1_err = ~oor1_q & (|lane_err);
`else
    assign s1_err = 1'b0;
`endif

    onchip_ram_array #(
        .LANES  (NB),
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk     (clk),
        .en_i    (en),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    if (READ_LAT == READ_LAT_MIN) begin : g_lat1
        assign out_v = v1_q;
        assign out_d = s1_data;
        assign out_e = s1_err;
    end else begin : g_lat2
        logic              v2_q;
        logic [DATA_W-1:0] d2_q;
        logic              e2_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                v2_q <= 1'b0;
                d2_q <= '0;
                e2_q <= 1'b0;
            end else if (en) begin
                v2_q <= v1_q;
                d2_q <= s1_data;
                e2_q <= s1_err;
            end
        end

        assign out_v = v2_q;
        assign out_d = d2_q;
        assign out_e = e2_q;
    end

    // A held pipeline only presents its result in an enabled cycle, so each read pulses once.
    assign readdatavalid = out_v & en & ~reset;
    assign readdata      = readdatavalid ? out_d : '0;
    assign parity_err    = readdatavalid & out_e;

endmodule

// File: tb/tb_onchip_ram_avl.sv
// Scoreboard bench for onchip_ram_avl (DEPTH=16, READ_LAT=2, clear on reset).
// Parity checks are compiled in when ONCHIP_RAM_PARITY_EN is defined.
module tb_onchip_ram_avl;

    localparam int RL    = 2;
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic        clk = 1'b0;
    logic        reset, clken, reset_req, chipselect, read, write;
    logic [AW-1:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid, waitrequest, parity_err;

    always #5 clk = ~clk;

    onchip_ram_avl #(
        .DATA_W         (32),
        .ADDR_W         (AW),
        .DEPTH          (DEPTH),
        .READ_LAT       (RL),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clken         (clken),
        .reset_req     (reset_req),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .address       (address),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .parity_err    (parity_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        perr;
        int          stamp;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int          ecnt  = 0;
    logic [31:0] model [DEPTH];

    always @(posedge clk) if (clken && !reset_req) ecnt <= ecnt + 1;

    // Monitor: compares every readdatavalid pulse against the head of the scoreboard.
    always @(negedge clk) begin
        total++;
        if (readdatavalid) begin
            if (!clken || reset_req || reset) begin
                bad++;
                $display("FAIL valid_gate: readdatavalid=1 with clken=%0b reset_req=%0b reset=%0b, required no pulse",
                         clken, reset_req, reset);
            end else if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: readdatavalid=1 data=%h, required no pending read", readdata);
            end else begin
                mon_e = sb_q.pop_front();
                $display("read  data=%h perr=%0b latency=%0d", readdata, parity_err, ecnt - mon_e.stamp);
                if (readdata !== mon_e.data || parity_err !== mon_e.perr || (ecnt - mon_e.stamp) != RL) begin
                    bad++;
                    $display("FAIL read_resp: data=%h perr=%0b lat=%0d, required data=%h perr=%0b lat=%0d",
                             readdata, parity_err, ecnt - mon_e.stamp, mon_e.data, mon_e.perr, RL);
                end
            end
        end else if (readdata !== 32'h0 || parity_err !== 1'b0) begin
            bad++;
            $display("FAIL idle_outputs: readdata=%h parity_err=%0b, required 0 and 0", readdata, parity_err);
        end
    end

    task automatic issue(input logic wr, input logic rd, input int a, input logic [3:0] be,
                         input logic [31:0] wd, input logic push, input logic [31:0] exp_d,
                         input logic exp_p);
        chipselect = 1'b1;
        write      = wr;
        read       = rd;
        address    = a[AW-1:0];
        byteenable = be;
        writedata  = wd;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!waitrequest) begin
                if (push) sb_q.push_back('{exp_d, exp_p, ecnt});
                if (wr) $display("write addr=%0d be=%b data=%h", a, be, wd);
                else    $display("req   addr=%0d", a);
                @(posedge clk);
                #1;
                chipselect = 1'b0;
                read       = 1'b0;
                write      = 1'b0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL accept_timeout: waitrequest=1 for 100 cycles at addr %0d, required 0", a);
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
    endtask

    task automatic wr_word(input int a, input logic [3:0] be, input logic [31:0] d);
        issue(1'b1, 1'b0, a, be, d, 1'b0, 32'h0, 1'b0);
        if (a < DEPTH)
            for (int b = 0; b < 4; b++)
                if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic rd_exp(input int a, input logic [31:0] exp_d);
        issue(1'b0, 1'b1, a, 4'h0, 32'h0, 1'b1, exp_d, 1'b0);
    endtask

    task automatic rd_model(input int a);
        rd_exp(a, (a < DEPTH) ? model[a] : 32'h0);
    endtask

    task automatic drain();
        for (int t = 0; t < 50; t++) begin
            if (sb_q.size() == 0) return;
            @(negedge clk);
        end
        total++;
        bad++;
        $display("FAIL drain_timeout: %0d reads pending, required 0", sb_q.size());
        sb_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (waitrequest !== 1'b1 || readdatavalid !== 1'b0 || readdata !== 32'h0 || parity_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: wr=%0b rdv=%0b rd=%h pe=%0b, required 1 0 0 0",
                     waitrequest, readdatavalid, readdata, parity_err);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic wait_clear(input int limit);
        int n;
        n = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!waitrequest) break;
            n++;
        end
        total++;
        if (n != DEPTH) begin
            bad++;
            $display("FAIL clear_cycles: waitrequest high %0d cycles, required %0d", n, DEPTH);
        end else begin
            $display("clear done after %0d cycles", n);
        end
        @(posedge clk);
        #1;
        if (limit < 0) $display("clear wait limit ignored");
    endtask

    initial begin
        reset      = 1'b1;
        clken      = 1'b1;
        reset_req  = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        byteenable = 4'h0;
        writedata  = 32'h0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        @(posedge clk);
        #1;

        // Zero-fill after reset, then every address reads back zero.
        do_reset();
        wait_clear(0);
        for (int i = 0; i < DEPTH; i++) rd_exp(i, 32'h0);
        drain();

        // Byte-enabled merge and a byteenable=0 write that must not change the word.
        wr_word(3, 4'hF, 32'hAABBCCDD);
        wr_word(3, 4'h5, 32'h11223344);
        rd_exp(3, 32'hAA22CC44);
        wr_word(3, 4'h0, 32'hFFFFFFFF);
        rd_exp(3, 32'hAA22CC44);
        drain();

        // Read and write together: the write wins, the read produces no response.
        issue(1'b1, 1'b1, 4, 4'hF, 32'h5A5A5A5A, 1'b0, 32'h0, 1'b0);
        model[4] = 32'h5A5A5A5A;
        rd_exp(4, 32'h5A5A5A5A);
        drain();

        // reset_req blocks access like clken low.
        reset_req = 1'b1;
        @(negedge clk);
        total++;
        if (waitrequest !== 1'b1) begin
            bad++;
            $display("FAIL reset_req_wait: waitrequest=%0b, required 1", waitrequest);
        end
        @(posedge clk);
        #1;
        reset_req = 1'b0;

        // Eight back-to-back reads with clken low for three cycles mid-burst.
        for (int i = 0; i < 8; i++) wr_word(i, 4'hF, {4{8'(i + 1)}});
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                clken = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                clken = 1'b1;
            end
            rd_exp(i, {4{8'(i + 1)}});
        end
        drain();

        // Out-of-range write is dropped; its read returns zero with a valid pulse.
        wr_word(DEPTH + 1, 4'hF, 32'hCAFEF00D);
        rd_exp(DEPTH + 1, 32'h0);
        for (int i = 0; i < DEPTH; i++) rd_model(i);
        drain();

`ifdef ONCHIP_RAM_PARITY_EN
        // Flip a stored data bit behind the parity bit's back.
        wr_word(5, 4'hF, 32'h00000055);
        dut.u_array.g_lane[0].mem_q[5][0] = ~dut.u_array.g_lane[0].mem_q[5][0];
        issue(1'b0, 1'b1, 5, 4'h0, 32'h0, 1'b1, 32'h00000054, 1'b1);
        drain();
`endif

        // Reset one cycle after a read is accepted: no response, and the clear restarts.
        wr_word(0, 4'hF, 32'hDEADBEEF);
        wr_word(15, 4'hF, 32'h12345678);
        issue(1'b0, 1'b1, 0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        do_reset();
        wait_clear(0);
        rd_exp(0, 32'h0);
        rd_exp(15, 32'h0);
        drain();

        repeat (4) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL pending_at_end: %0d reads outstanding, required 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
